// File: rtl/key_draw_pkg.sv
// Shared definitions for the key box drawer: FSM state codes, screen size,
// key colours and the (x, y, on) request tuple.
package key_draw_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_ON  = 3'b010;
    localparam logic [2:0] COLOUR_OFF = 3'b000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       on;
    } key_req_t;

endpackage

// File: rtl/box_scan_counter.sv
// Row-major scan counter over a BOX_W x BOX_H box; flags the last pixel.
module box_scan_counter #(
    parameter int BOX_W = 8,
    parameter int BOX_H = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic       last
);

    localparam logic [3:0] CX_MAX = 4'(BOX_W - 1);
    localparam logic [3:0] CY_MAX = 4'(BOX_H - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (cx == CX_MAX) begin
                cx <= '0;
                cy <= (cy == CY_MAX) ? 4'd0 : cy + 4'd1;
            end else begin
                cx <= cx + 4'd1;
            end
        end
    end

    assign last = (cx == CX_MAX) && (cy == CY_MAX);

endmodule

// File: rtl/key_box_drawer.sv
// Rasterises one key box per accepted request into the 160x120 VGA frame buffer.
// Define KEY_BOX_OUTLINE_EN to plot only the box perimeter (same scan timing).
module key_box_drawer #(
    parameter int         BOX_W      = 8,
    parameter int         BOX_H      = 8,
    parameter logic [2:0] ON_COLOUR  = key_draw_pkg::COLOUR_ON,
    parameter logic [2:0] OFF_COLOUR = key_draw_pkg::COLOUR_OFF,
    parameter int         SCREEN_W   = key_draw_pkg::SCREEN_W,
    parameter int         SCREEN_H   = key_draw_pkg::SCREEN_H
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key_x,
    input  logic [6:0] key_y,
    input  logic       key_valid,
    input  logic       key_on,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);
    import key_draw_pkg::*;

    localparam logic [3:0] CX_MAX = 4'(BOX_W - 1);
    localparam logic [3:0] CY_MAX = 4'(BOX_H - 1);
    localparam logic [8:0] LIM_X  = 9'(SCREEN_W);
    localparam logic [7:0] LIM_Y  = 8'(SCREEN_H);

    logic [1:0] state;
    key_req_t   live, last_q, pend_q, take;
    logic       last_valid, pend_valid;
    logic       live_req, accept;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] colour_q;
    logic [3:0] cx, cy;
    logic       scan_last;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       on_screen, perimeter;

    assign live     = {key_x, key_y, key_on};
    // Comparing against the last-accepted tuple both suppresses held keys
    // and keeps the box currently being drawn out of the pending slot.
    assign live_req = key_valid && (!last_valid || (live != last_q));
    assign accept   = (state == ST_IDLE) && (pend_valid || live_req);
    assign take     = pend_valid ? pend_q : live;
    assign busy     = (state == ST_LOAD) || (state == ST_DRAW);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_q     <= '0;
            last_valid <= 1'b0;
            pend_q     <= '0;
            pend_valid <= 1'b0;
            base_x     <= '0;
            base_y     <= '0;
            colour_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    base_x     <= take.x;
                    base_y     <= take.y;
                    colour_q   <= take.on ? ON_COLOUR : OFF_COLOUR;
                    last_q     <= take;
                    last_valid <= 1'b1;
                    pend_valid <= 1'b0;
                    state      <= ST_LOAD;
                end
                ST_LOAD: state <= ST_DRAW;
                ST_DRAW: if (scan_last) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
            if ((state != ST_IDLE) && live_req) begin
                pend_q     <= live;
                pend_valid <= 1'b1;
            end
        end
    end

    box_scan_counter #(
        .BOX_W(BOX_W),
        .BOX_H(BOX_H)
    ) u_scan (
        .clock (clock),
        .reset (reset),
        .clear (state == ST_LOAD),
        .enable(state == ST_DRAW),
        .cx    (cx),
        .cy    (cy),
        .last  (scan_last)
    );

    // Sums are one bit wider than the ports so wrapped pixels stay clipped.
    assign sum_x     = {1'b0, base_x} + {5'd0, cx};
    assign sum_y     = {1'b0, base_y} + {4'd0, cy};
    assign on_screen = (sum_x < LIM_X) && (sum_y < LIM_Y);
`ifdef KEY_BOX_OUTLINE_EN
    assign perimeter = (cx == 4'd0) || (cx == CX_MAX) || (cy == 4'd0) || (cy == CY_MAX);
`else
    assign perimeter = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_DRAW) begin
                vga_x      <= sum_x[7:0];
                vga_y      <= sum_y[6:0];
                vga_colour <= colour_q;
                vga_plot   <= on_screen && perimeter;
            end else begin
                vga_plot   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_box_drawer.sv
// Self-checking bench for key_box_drawer: plot scoreboard plus timing checks.
module tb_key_box_drawer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] key_x;
    logic [6:0] key_y;
    logic       key_valid;
    logic       key_on;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    logic [17:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    int first_plot_cyc = -1;
    int done_cyc = -1;
    int accept_cyc = 0;

    key_box_drawer dut (
        .clock     (clock),
        .reset     (reset),
        .key_x     (key_x),
        .key_y     (key_y),
        .key_valid (key_valid),
        .key_on    (key_on),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .busy      (busy),
        .done      (done)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clock) begin
        logic [17:0] obs, exp_v;
        if (vga_plot === 1'b1) begin
            obs = {vga_x, vga_y, vga_colour};
            if (plot_cnt == 0) first_plot_cyc = cyc;
            plot_cnt++;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%b, expected no plot", vga_x, vga_y, vga_colour);
            end else begin
                exp_v = exp_q.pop_front();
                if (obs !== exp_v) begin
                    err_cnt++;
                    $display("FAIL plot_pixel: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b",
                             vga_x, vga_y, vga_colour, exp_v[17:10], exp_v[9:3], exp_v[2:0]);
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic push_box(input int x, input int y, input logic on);
        logic [2:0] col;
        int sx, sy;
        logic keep;
        col = on ? 3'b010 : 3'b000;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                sx = x + c;
                sy = y + r;
`ifdef KEY_BOX_OUTLINE_EN
                keep = (r == 0) || (r == 7) || (c == 0) || (c == 7);
`else
                keep = 1'b1;
`endif
                if (sx < 160 && sy < 120 && keep)
                    exp_q.push_back({8'(sx), 7'(sy), col});
            end
        end
    endtask

    task automatic clear_stats();
        plot_cnt = 0;
        done_cnt = 0;
        first_plot_cyc = -1;
        done_cyc = -1;
    endtask

    // driver: called just after a rising edge; DUT samples on the next one
    task automatic drive_key(input int x, input int y, input logic on, input logic v);
        key_x = 8'(x);
        key_y = 7'(y);
        key_on = on;
        key_valid = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic check_box(input string name, input int plots, input int dones,
                             input int first_off, input int done_off);
        vec_cnt++;
        if (plot_cnt !== plots) begin
            err_cnt++;
            $display("FAIL %s_plots: got %0d, expected %0d", name, plot_cnt, plots);
        end
        vec_cnt++;
        if (done_cnt !== dones) begin
            err_cnt++;
            $display("FAIL %s_dones: got %0d, expected %0d", name, done_cnt, dones);
        end
        if (first_off >= 0) begin
            vec_cnt++;
            if (first_plot_cyc !== accept_cyc + first_off) begin
                err_cnt++;
                $display("FAIL %s_first_plot: got cycle %0d, expected %0d", name, first_plot_cyc, accept_cyc + first_off);
            end
        end
        vec_cnt++;
        if (done_cyc !== accept_cyc + done_off) begin
            err_cnt++;
            $display("FAIL %s_done_time: got cycle %0d, expected %0d", name, done_cyc, accept_cyc + done_off);
        end
        vec_cnt++;
        if (exp_q.size() !== 0) begin
            err_cnt++;
            $display("FAIL %s_leftover: got %0d pixels not drawn, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_key(0, 0, 1'b0, 1'b0);
        wait_cycles(3);
        vec_cnt++;
        if ({vga_x, vga_y, vga_colour, vga_plot, busy, done} !== 21'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%b plot=%b busy=%b done=%b, expected all 0",
                     vga_x, vga_y, vga_colour, vga_plot, busy, done);
        end
        reset = 1'b0;
        wait_cycles(2);
        clear_stats();
    endtask

    task automatic test_fill_held();
        drive_key(52, 30, 1'b1, 1'b1);
        accept_cyc = cyc + 1;
        push_box(52, 30, 1'b1);
        wait_cycles(1);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL fill_busy: got %b, expected 1", busy);
        end
        wait_cycles(199);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL fill_idle: got busy=%b, expected 0", busy);
        end
        check_box("fill", 64, 1, 2, 66);
        clear_stats();
    endtask

    task automatic test_clip_corner();
        drive_key(156, 116, 1'b1, 1'b1);
        accept_cyc = cyc + 1;
        push_box(156, 116, 1'b1);
        wait_cycles(100);
        check_box("corner", 16, 1, 2, 66);
        clear_stats();
    endtask

    task automatic test_offscreen();
        drive_key(200, 125, 1'b1, 1'b1);
        accept_cyc = cyc + 1;
        wait_cycles(100);
        check_box("offscreen", 0, 1, -1, 66);
        clear_stats();
    endtask

    task automatic test_latest_wins();
        drive_key(52, 30, 1'b1, 1'b1);
        accept_cyc = cyc + 1;
        push_box(52, 30, 1'b1);
        push_box(24, 5, 1'b1);
        wait_cycles(10);
        drive_key(5, 3, 1'b1, 1'b1);
        wait_cycles(5);
        drive_key(24, 5, 1'b1, 1'b1);
        wait_cycles(185);
        // second box starts from the IDLE cycle after the first DONE
        check_box("latest", 128, 2, 2, 133);
        clear_stats();
    endtask

    task automatic test_release();
        drive_key(52, 30, 1'b0, 1'b1);
        accept_cyc = cyc + 1;
        push_box(52, 30, 1'b0);
        wait_cycles(100);
        check_box("release", 64, 1, 2, 66);
        clear_stats();
    endtask

    task automatic test_reset_mid_draw();
        int guard;
        drive_key(52, 30, 1'b1, 1'b1);
        push_box(52, 30, 1'b1);
        guard = 0;
        while (plot_cnt < 20 && guard < 100) begin
            wait_cycles(1);
            guard++;
        end
        vec_cnt++;
        if (plot_cnt < 20) begin
            err_cnt++;
            $display("FAIL midreset_reach: got %0d plots, expected 20 within 100 cycles", plot_cnt);
        end
        reset = 1'b1;
        #1;
        vec_cnt++;
        if ({vga_plot, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL midreset_now: got plot=%b busy=%b, expected 0 0", vga_plot, busy);
        end
        exp_q.delete();
        wait_cycles(2);
        reset = 1'b0;
        clear_stats();
        accept_cyc = cyc + 1;
        push_box(52, 30, 1'b1);
        wait_cycles(100);
        check_box("redraw", 64, 1, 2, 66);
        clear_stats();
    endtask

    task automatic test_outline_box();
        int n;
`ifdef KEY_BOX_OUTLINE_EN
        n = 28;
`else
        n = 64;
`endif
        drive_key(10, 10, 1'b1, 1'b1);
        accept_cyc = cyc + 1;
        push_box(10, 10, 1'b1);
        wait_cycles(100);
        check_box("box10", n, 1, 2, 66);
        clear_stats();
    endtask

    initial begin
        test_reset();
        test_fill_held();
        test_clip_corner();
        test_offscreen();
        test_latest_wins();
        test_release();
        test_reset_mid_draw();
        test_outline_box();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
